// File: rtl/ram_bus_arbiter_pkg.sv
// Shared encodings for the two-port TestRam arbiter.
// State, requester id and read/write direction codes.
package ram_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  localparam logic ID_R0 = 1'b0;
  localparam logic ID_R1 = 1'b1;

  localparam logic RDWR_READ  = 1'b0;
  localparam logic RDWR_WRITE = 1'b1;

  function automatic logic is_write(input logic rdwr);
    return rdwr == RDWR_WRITE;
  endfunction

endpackage

// File: rtl/ram_arb_rr_pick.sv
// Round-robin pick between two request levels.
// On a tie the requester that was not served last wins.
module ram_arb_rr_pick
  import ram_bus_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic id
);

  always_comb begin
    valid = req0 | req1;
    id    = ID_R1;
    unique case (1'b1)
      req0 && req1:  id = ~last_grant;
      req0 && !req1: id = ID_R0;
      default:       id = ID_R1;
    endcase
  end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Shares a single-port TestRam between r0 (cpu) and r1 (loader).
// One access at a time: IDLE -> ISSUE -> (WAIT) -> DONE.
module ram_bus_arbiter
  import ram_bus_arbiter_pkg::*;
#(
  parameter int ADDR_MSB_POS = 15,
  parameter int DATA_MSB_POS = 7,
  parameter int WAIT_LIMIT   = 15,
  parameter int WAIT_CNT_MSB = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_req,
  input  logic                  r1_req,
  input  logic                  r0_which_rdwr,
  input  logic                  r1_which_rdwr,
  input  logic [ADDR_MSB_POS:0] r0_addr,
  input  logic [ADDR_MSB_POS:0] r1_addr,
  input  logic [DATA_MSB_POS:0] r0_data_out,
  input  logic [DATA_MSB_POS:0] r1_data_out,
  output logic                  r0_ack,
  output logic                  r1_ack,
  output logic [DATA_MSB_POS:0] rdata,
  output logic                  timeout_err,
  output logic                  busy,
  output logic                  grant_id,
  output logic                  ram_we,
  output logic [ADDR_MSB_POS:0] ram_addr,
  output logic [DATA_MSB_POS:0] ram_data_in,
  input  logic [DATA_MSB_POS:0] ram_data_out,
  input  logic                  ram_data_ready
);

  localparam int CW = WAIT_CNT_MSB + 1;
  localparam logic [WAIT_CNT_MSB:0] LIMIT = CW'(WAIT_LIMIT);

  arb_state_t            state;
  logic                  last_grant;
  logic                  is_wr;
  logic [WAIT_CNT_MSB:0] wait_cnt;

  logic                  pick_valid;
  logic                  pick_id;
  logic                  sel_rdwr;
  logic [ADDR_MSB_POS:0] sel_addr;
  logic [DATA_MSB_POS:0] sel_data;

  ram_arb_rr_pick u_pick (
    .req0       (r0_req),
    .req1       (r1_req),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .id         (pick_id)
  );

  assign sel_rdwr = pick_id ? r1_which_rdwr : r0_which_rdwr;
  assign sel_addr = pick_id ? r1_addr : r0_addr;
  assign sel_data = pick_id ? r1_data_out : r0_data_out;

  // The RAM address/data registers double as the request latch,
  // so they are loaded at grant and are valid throughout ISSUE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_data_in <= '0;
      r0_ack      <= 1'b0;
      r1_ack      <= 1'b0;
      rdata       <= '0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      grant_id    <= ID_R1;
      last_grant  <= ID_R1;
      is_wr       <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      r0_ack      <= 1'b0;
      r1_ack      <= 1'b0;
      timeout_err <= 1'b0;
      ram_we      <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state       <= ST_ISSUE;
            busy        <= 1'b1;
            grant_id    <= pick_id;
            is_wr       <= is_write(sel_rdwr);
            ram_we      <= is_write(sel_rdwr);
            ram_addr    <= sel_addr;
            ram_data_in <= sel_data;
          end
        end
        ST_ISSUE: begin
          if (is_wr) begin
            state  <= ST_DONE;
            r0_ack <= (grant_id == ID_R0);
            r1_ack <= (grant_id == ID_R1);
          end else begin
            state    <= ST_WAIT;
            wait_cnt <= CW'(1);
          end
        end
        ST_WAIT: begin
          if (ram_data_ready) begin
            rdata  <= ram_data_out;
            state  <= ST_DONE;
            r0_ack <= (grant_id == ID_R0);
            r1_ack <= (grant_id == ID_R1);
          end else if (wait_cnt == LIMIT) begin
            rdata       <= '1;
            timeout_err <= 1'b1;
            state       <= ST_DONE;
            r0_ack      <= (grant_id == ID_R0);
            r1_ack      <= (grant_id == ID_R1);
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          busy       <= 1'b0;
          last_grant <= grant_id;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  a_ack_onehot: assert property (
    @(posedge clk) !(r0_ack && r1_ack));
  a_to_with_ack: assert property (
    @(posedge clk) timeout_err |-> (r0_ack || r1_ack));
  a_we_in_issue: assert property (
    @(posedge clk) ram_we |-> (state == ST_ISSUE));

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Scoreboard bench for ram_bus_arbiter with a TestRam model.
module tb_ram_bus_arbiter;

  localparam int WL = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        r0_req = 1'b0, r1_req = 1'b0;
  logic        r0_which_rdwr = 1'b0, r1_which_rdwr = 1'b0;
  logic [15:0] r0_addr = '0, r1_addr = '0;
  logic [7:0]  r0_data_out = '0, r1_data_out = '0;
  logic        r0_ack, r1_ack;
  logic [7:0]  rdata;
  logic        timeout_err, busy, grant_id, ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_data_in;
  logic [7:0]  ram_data_out = '0;
  logic        ram_data_ready = 1'b0;

  ram_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r1_req(r1_req),
    .r0_which_rdwr(r0_which_rdwr), .r1_which_rdwr(r1_which_rdwr),
    .r0_addr(r0_addr), .r1_addr(r1_addr),
    .r0_data_out(r0_data_out), .r1_data_out(r1_data_out),
    .r0_ack(r0_ack), .r1_ack(r1_ack),
    .rdata(rdata), .timeout_err(timeout_err),
    .busy(busy), .grant_id(grant_id),
    .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
    .ram_data_ready(ram_data_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         wr;
    logic [7:0] data;
    bit         to;
    int         cyc;
  } ack_exp_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_exp_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  ack_exp_t ack_q0[$], ack_q1[$];
  wr_exp_t  wr_q0[$], wr_q1[$];

  logic [7:0] ref_mem [logic [15:0]];
  logic [7:0] ram_mem [logic [15:0]];

  // WAIT cycle in which the TestRam model answers, chosen by addr[10:8]
  int ktab [8] = '{1, 2, 3, 5, 14, 15, 16, 20};

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  always @(posedge clk) cyc++;

  // TestRam model: counts cycles from the start of each access
  int  rc = 0;
  bit  prev_busy = 1'b0;
  always @(posedge clk) begin
    wr_exp_t w;
    #1;
    if (ram_we) begin
      ram_mem[ram_addr] = ram_data_in;
      checks++;
      if (ram_addr[15] ? wr_q1.size() == 0 : wr_q0.size() == 0) begin
        errors++;
        $display("FAIL ram_we_unexpected: addr %h data %h, no write pending",
                 ram_addr, ram_data_in);
      end else begin
        w = ram_addr[15] ? wr_q1.pop_front() : wr_q0.pop_front();
        if (ram_addr !== w.addr || ram_data_in !== w.data ||
            (w.cyc >= 0 && cyc != w.cyc)) begin
          errors++;
          $display("FAIL ram_write: got %h/%h @%0d exp %h/%h @%0d",
                   ram_addr, ram_data_in, cyc, w.addr, w.data, w.cyc);
        end
      end
    end
    if (busy && !prev_busy) rc = 0;
    else rc = rc + 1;
    prev_busy = busy;
    ram_data_ready = 1'b0;
    ram_data_out = 8'($urandom);
    if (busy) begin
      if (rc == 0) begin
        ram_data_ready = 1'($urandom_range(1));
      end else if (rc == ktab[ram_addr[10:8]]) begin
        ram_data_ready = 1'b1;
        ram_data_out = ram_mem.exists(ram_addr) ? ram_mem[ram_addr]
                                                : init_val(ram_addr);
      end
    end
  end

  bit prev0 = 1'b0, prev1 = 1'b0;

  task automatic check_ack(input int p);
    ack_exp_t e;
    checks++;
    if (p == 0 ? ack_q0.size() == 0 : ack_q1.size() == 0) begin
      errors++;
      $display("FAIL ack%0d_unexpected: ack=1 exp 0 at cycle %0d", p, cyc);
      return;
    end
    e = (p == 0) ? ack_q0.pop_front() : ack_q1.pop_front();
    if (!e.wr && rdata !== e.data) begin
      errors++;
      $display("FAIL ack%0d_rdata: got %h exp %h", p, rdata, e.data);
    end
    checks++;
    if (timeout_err !== e.to) begin
      errors++;
      $display("FAIL ack%0d_timeout_err: got %b exp %b", p, timeout_err, e.to);
    end
    checks++;
    if (grant_id !== 1'(p)) begin
      errors++;
      $display("FAIL ack%0d_grant_id: got %b exp %0d", p, grant_id, p);
    end
    checks++;
    if ((p == 0 ? prev0 : prev1) == 1'b1) begin
      errors++;
      $display("FAIL ack%0d_pulse: ack high 2 cycles, exp 1", p);
    end
    if (e.cyc >= 0) begin
      checks++;
      if (cyc != e.cyc) begin
        errors++;
        $display("FAIL ack%0d_latency: got cycle %0d exp %0d", p, cyc, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (r0_ack) check_ack(0);
    if (r1_ack) check_ack(1);
    if (r0_ack && r1_ack) begin
      errors++;
      $display("FAIL ack_both: r0_ack=1 r1_ack=1 exp one-hot");
    end
    if (timeout_err && !r0_ack && !r1_ack) begin
      checks++;
      errors++;
      $display("FAIL timeout_lone: timeout_err=1 without ack");
    end
    prev0 = r0_ack;
    prev1 = r1_ack;
  end

  // Issue one access from port p and hold req until its ack.
  task automatic do_req(input int p, input bit wr, input logic [15:0] a,
                        input logic [7:0] d, input int ec);
    ack_exp_t e;
    wr_exp_t  w;
    int       k;
    bit       got;
    int       n;
    e.wr = wr; e.cyc = ec; e.to = 1'b0; e.data = '0;
    if (wr) begin
      ref_mem[a] = d;
      w.addr = a; w.data = d; w.cyc = (ec < 0) ? -1 : ec - 1;
      if (p == 0) wr_q0.push_back(w);
      else wr_q1.push_back(w);
    end else begin
      k = ktab[a[10:8]];
      if (k <= WL) e.data = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
      else begin
        e.data = 8'hFF;
        e.to = 1'b1;
      end
    end
    if (p == 0) begin
      ack_q0.push_back(e);
      r0_which_rdwr = wr; r0_addr = a; r0_data_out = d; r0_req = 1'b1;
    end else begin
      ack_q1.push_back(e);
      r1_which_rdwr = wr; r1_addr = a; r1_data_out = d; r1_req = 1'b1;
    end
    got = 1'b0;
    n = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      got = (p == 0) ? r0_ack : r1_ack;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_wait%0d: no ack within 100 cycles", p);
    end
    @(posedge clk);
    #1;
    if (p == 0) begin
      r0_req = 1'b0; r0_addr = 16'($urandom); r0_data_out = 8'($urandom);
    end else begin
      r1_req = 1'b0; r1_addr = 16'($urandom); r1_data_out = 8'($urandom);
    end
  endtask

  task automatic rand_port(input int p);
    logic [15:0] a;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(3)) begin
        @(posedge clk);
        #1;
      end
      a = {p[0], 4'b0, 3'($urandom_range(7)), 5'b0, 3'($urandom_range(7))};
      do_req(p, 1'($urandom_range(1)), a, 8'($urandom), -1);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (busy !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 16'h0 ||
        ram_data_in !== 8'h0 || r0_ack !== 1'b0 || r1_ack !== 1'b0 ||
        grant_id !== 1'b1 || rdata !== 8'h0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy=%b we=%b addr=%h din=%h ack=%b%b gid=%b rdata=%h to=%b exp 0 0 0000 00 00 1 00 0",
               tag, busy, ram_we, ram_addr, ram_data_in, r0_ack, r1_ack,
               grant_id, rdata, timeout_err);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check_reset_outputs("reset_idle");
    end
    @(posedge clk);
    #1;

    n = cyc;
    do_req(0, 1'b1, 16'h0010, 8'hA5, n + 2);
    n = cyc;
    do_req(0, 1'b0, 16'h0010, 8'h00, n + 3);

    do_reset();
    n = cyc;
    fork
      begin
        do_req(0, 1'b0, 16'h0010, 8'h00, n + 3);
        do_req(0, 1'b0, 16'h0010, 8'h00, n + 11);
      end
      begin
        do_req(1, 1'b0, 16'h8010, 8'h00, n + 7);
        do_req(1, 1'b0, 16'h8010, 8'h00, n + 15);
      end
    join

    n = cyc;
    do_req(1, 1'b0, 16'h8700, 8'h00, n + 17);
    n = cyc;
    do_req(1, 1'b0, 16'h8600, 8'h00, n + 17);
    n = cyc;
    do_req(1, 1'b0, 16'h8010, 8'h00, n + 3);

    n = cyc;
    do_req(0, 1'b1, 16'h0500, 8'h3C, n + 2);
    n = cyc;
    do_req(0, 1'b0, 16'h0500, 8'h00, n + 17);

    // reset in the middle of a slow read: no ack may follow
    r0_which_rdwr = 1'b0; r0_addr = 16'h0700; r0_req = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    r0_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_in_wait");
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    n = cyc;
    do_req(0, 1'b0, 16'h0010, 8'h00, n + 3);

    fork
      rand_port(0);
      rand_port(1);
    join

    repeat (5) @(posedge clk);
    checks++;
    if (ack_q0.size() + ack_q1.size() + wr_q0.size() + wr_q1.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, exp 0",
               ack_q0.size() + ack_q1.size() + wr_q0.size() + wr_q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
